// File: rtl/memory_stage_pkg.sv
// Shared opcode encodings, widths and FSM state type for the memory stage.
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 6'b100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 6'b101011;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

    // True for opcodes that need a data-memory transfer.
    function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack port,
// upstream stall while a transfer is outstanding, misalign/timeout error.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int RWIDTH  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                    ms_clk,
    input  logic                    ms_rst,
    input  logic                    ms_i_ce,
    input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  ms_i_funct,
    input  logic [DWIDTH-1:0]       ms_i_alu_value,
    input  logic                    ms_i_zero,
    input  logic [DWIDTH-1:0]       ms_i_store_data,
    input  logic [RWIDTH-1:0]       ms_i_rd,
    output logic                    ms_o_stall,
    output logic                    ms_o_mem_req,
    output logic                    ms_o_mem_we,
    output logic [DWIDTH-1:0]       ms_o_mem_addr,
    output logic [DWIDTH-1:0]       ms_o_mem_wdata,
    input  logic                    ms_i_mem_ack,
    input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
    output logic                    ms_o_ce,
    output logic [DWIDTH-1:0]       ms_o_wb_data,
    output logic [RWIDTH-1:0]       ms_o_rd,
    output logic                    ms_o_regwrite,
    output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  ms_o_funct,
    output logic                    ms_o_zero,
    output logic                    ms_o_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    ms_state_t               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [DWIDTH-1:0]       addr_q, addr_d;
    logic [DWIDTH-1:0]       wdata_q, wdata_d;
    logic                    ce_q, ce_d;
    logic [DWIDTH-1:0]       wb_q, wb_d;
    logic [RWIDTH-1:0]       rd_q, rd_d;
    logic                    rw_q, rw_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [FUNCT_WIDTH-1:0]  fn_q, fn_d;
    logic                    zero_q, zero_d;
    logic                    err_q, err_d;

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ce_d    = ce_q;
        wb_d    = wb_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        op_d    = op_q;
        fn_d    = fn_q;
        zero_d  = zero_q;
        err_d   = err_q;

        case (state_q)
            MS_IDLE: begin
                if (!ms_i_ce) begin
                    ce_d  = 1'b0;
                    wb_d  = '0;
                    rw_d  = 1'b0;
                    err_d = 1'b0;
                end else begin
                    rd_d   = ms_i_rd;
                    op_d   = ms_i_opcode;
                    fn_d   = ms_i_funct;
                    zero_d = ms_i_zero;
                    if (!is_mem_op(ms_i_opcode)) begin
                        wb_d  = ms_i_alu_value;
                        rw_d  = 1'b1;
                        ce_d  = 1'b1;
                        err_d = 1'b0;
                    end else if (ms_i_alu_value[1:0] != 2'b00) begin
                        // Misaligned word access: report without touching memory.
                        wb_d  = '0;
                        rw_d  = 1'b0;
                        ce_d  = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        addr_d  = ms_i_alu_value;
                        we_d    = (ms_i_opcode == OP_STORE);
                        wdata_d = (ms_i_opcode == OP_STORE) ? ms_i_store_data : '0;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        ce_d    = 1'b0;
                        wb_d    = '0;
                        rw_d    = 1'b0;
                        err_d   = 1'b0;
                        state_d = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                ce_d = 1'b0;
                if (ms_i_mem_ack) begin
                    req_d   = 1'b0;
                    ce_d    = 1'b1;
                    err_d   = 1'b0;
                    wb_d    = we_q ? addr_q : ms_i_mem_rdata;
                    rw_d    = !we_q;
                    state_d = MS_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    ce_d    = 1'b1;
                    err_d   = 1'b1;
                    rw_d    = 1'b0;
                    wb_d    = '0;
                    state_d = MS_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    // State, counter and output registers; reset clears everything and aborts a transfer.
    always_ff @(posedge ms_clk) begin
        if (ms_rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_q    <= 1'b0;
            wb_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            op_q    <= '0;
            fn_q    <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_q    <= ce_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign ms_o_stall     = (state_q == MS_WAIT);
    assign ms_o_mem_req   = req_q;
    assign ms_o_mem_we    = we_q;
    assign ms_o_mem_addr  = addr_q;
    assign ms_o_mem_wdata = wdata_q;
    assign ms_o_ce        = ce_q;
    assign ms_o_wb_data   = wb_q;
    assign ms_o_rd        = rd_q;
    assign ms_o_regwrite  = rw_q;
    assign ms_o_opcode    = op_q;
    assign ms_o_funct     = fn_q;
    assign ms_o_zero      = zero_q;
    assign ms_o_err       = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected results,
// a negedge monitor pops and compares on every ms_o_ce pulse.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    logic          ms_clk = 1'b0;
    logic          ms_rst;
    logic          ms_i_ce;
    logic [5:0]    ms_i_opcode;
    logic [5:0]    ms_i_funct;
    logic [DW-1:0] ms_i_alu_value;
    logic          ms_i_zero;
    logic [DW-1:0] ms_i_store_data;
    logic [RW-1:0] ms_i_rd;
    logic          ms_o_stall;
    logic          ms_o_mem_req;
    logic          ms_o_mem_we;
    logic [DW-1:0] ms_o_mem_addr;
    logic [DW-1:0] ms_o_mem_wdata;
    logic          ms_i_mem_ack;
    logic [DW-1:0] ms_i_mem_rdata;
    logic          ms_o_ce;
    logic [DW-1:0] ms_o_wb_data;
    logic [RW-1:0] ms_o_rd;
    logic          ms_o_regwrite;
    logic [5:0]    ms_o_opcode;
    logic [5:0]    ms_o_funct;
    logic          ms_o_zero;
    logic          ms_o_err;

    memory_stage #(.DWIDTH(DW), .RWIDTH(RW), .TIMEOUT(TO)) dut (
        .ms_clk(ms_clk), .ms_rst(ms_rst), .ms_i_ce(ms_i_ce),
        .ms_i_opcode(ms_i_opcode), .ms_i_funct(ms_i_funct),
        .ms_i_alu_value(ms_i_alu_value), .ms_i_zero(ms_i_zero),
        .ms_i_store_data(ms_i_store_data), .ms_i_rd(ms_i_rd),
        .ms_o_stall(ms_o_stall), .ms_o_mem_req(ms_o_mem_req),
        .ms_o_mem_we(ms_o_mem_we), .ms_o_mem_addr(ms_o_mem_addr),
        .ms_o_mem_wdata(ms_o_mem_wdata), .ms_i_mem_ack(ms_i_mem_ack),
        .ms_i_mem_rdata(ms_i_mem_rdata), .ms_o_ce(ms_o_ce),
        .ms_o_wb_data(ms_o_wb_data), .ms_o_rd(ms_o_rd),
        .ms_o_regwrite(ms_o_regwrite), .ms_o_opcode(ms_o_opcode),
        .ms_o_funct(ms_o_funct), .ms_o_zero(ms_o_zero), .ms_o_err(ms_o_err)
    );

    always #5 ms_clk = ~ms_clk;

    typedef struct {
        logic [DW-1:0] wb;
        logic [RW-1:0] rd;
        logic          rw;
        logic          err;
        logic          pt;   // also compare rd/opcode/funct/zero
        logic [5:0]    op;
        logic [5:0]    fn;
        logic          z;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge ms_clk);
        #1;
    endtask

    task automatic expect_res(input logic [DW-1:0] wb, input logic [RW-1:0] rd, input logic rw,
                              input logic err, input logic pt, input logic [5:0] op,
                              input logic [5:0] fn, input logic z);
        exp_t e;
        e.wb = wb; e.rd = rd; e.rw = rw; e.err = err; e.pt = pt; e.op = op; e.fn = fn; e.z = z;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [DW-1:0] alu,
                         input logic [DW-1:0] sd, input logic [RW-1:0] rd, input logic z);
        ms_i_ce = 1'b1; ms_i_opcode = op; ms_i_funct = fn; ms_i_alu_value = alu;
        ms_i_store_data = sd; ms_i_rd = rd; ms_i_zero = z;
    endtask

    // Monitor: every result pulse must match the oldest expected entry.
    always @(negedge ms_clk) begin
        if (ms_o_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ce", ms_o_ce, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_data", ms_o_wb_data, e.wb);
                chk("regwrite", 32'(ms_o_regwrite), 32'(e.rw));
                chk("err", 32'(ms_o_err), 32'(e.err));
                if (e.pt) begin
                    chk("rd", 32'(ms_o_rd), 32'(e.rd));
                    chk("opcode", 32'(ms_o_opcode), 32'(e.op));
                    chk("funct", 32'(ms_o_funct), 32'(e.fn));
                    chk("zero", 32'(ms_o_zero), 32'(e.z));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ce"}, 32'(ms_o_ce), 0);
        chk({tag, "_req"}, 32'(ms_o_mem_req), 0);
        chk({tag, "_we"}, 32'(ms_o_mem_we), 0);
        chk({tag, "_addr"}, ms_o_mem_addr, 0);
        chk({tag, "_wdata"}, ms_o_mem_wdata, 0);
        chk({tag, "_wb"}, ms_o_wb_data, 0);
        chk({tag, "_rd"}, 32'(ms_o_rd), 0);
        chk({tag, "_rw"}, 32'(ms_o_regwrite), 0);
        chk({tag, "_op"}, 32'(ms_o_opcode), 0);
        chk({tag, "_fn"}, 32'(ms_o_funct), 0);
        chk({tag, "_zero"}, 32'(ms_o_zero), 0);
        chk({tag, "_err"}, 32'(ms_o_err), 0);
        chk({tag, "_stall"}, 32'(ms_o_stall), 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ms_rst = 1'b1; ms_i_ce = 1'b0; ms_i_opcode = '0; ms_i_funct = '0;
        ms_i_alu_value = '0; ms_i_zero = 1'b0; ms_i_store_data = '0; ms_i_rd = '0;
        ms_i_mem_ack = 1'b0; ms_i_mem_rdata = '0;
        tick(); tick();
        chk_all_zero("reset");
        ms_rst = 1'b0;
        tick();

        // R-type ADD: 1-cycle latency result
        expect_res(32'h7, 5'd3, 1'b1, 1'b0, 1'b1, 6'h00, 6'h20, 1'b0);
        drive(6'h00, 6'h20, 32'h0000_0007, 32'h0, 5'd3, 1'b0);
        tick();
        ms_i_ce = 1'b0;
        chk("add_stall", 32'(ms_o_stall), 0);
        chk("add_req", 32'(ms_o_mem_req), 0);
        tick();

        // LOAD 0x100, ack on the third WAIT cycle; junk ADD held on inputs meanwhile
        expect_res(32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b1, OP_LOAD, 6'h00, 1'b1);
        drive(OP_LOAD, 6'h00, 32'h0000_0100, 32'hFFFF_FFFF, 5'd5, 1'b1);
        tick();
        drive(6'h00, 6'h20, 32'h0000_0055, 32'h0, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 32'(ms_o_stall), 1);
            chk("ld_req", 32'(ms_o_mem_req), 1);
            chk("ld_addr", ms_o_mem_addr, 32'h100);
            chk("ld_we", 32'(ms_o_mem_we), 0);
            chk("ld_ce_wait", 32'(ms_o_ce), 0);
            if (i == 2) begin
                ms_i_mem_ack = 1'b1; ms_i_mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        ms_i_mem_ack = 1'b0; ms_i_mem_rdata = '0; ms_i_ce = 1'b0;
        chk("ld_stall_done", 32'(ms_o_stall), 0);
        chk("ld_req_done", 32'(ms_o_mem_req), 0);
        tick();

        // STORE 0x204, ack on first WAIT cycle
        expect_res(32'h0000_0204, 5'd7, 1'b0, 1'b0, 1'b1, OP_STORE, 6'h00, 1'b0);
        drive(OP_STORE, 6'h00, 32'h0000_0204, 32'h1234_5678, 5'd7, 1'b0);
        tick();
        ms_i_ce = 1'b0;
        chk("st_req", 32'(ms_o_mem_req), 1);
        chk("st_we", 32'(ms_o_mem_we), 1);
        chk("st_addr", ms_o_mem_addr, 32'h204);
        chk("st_wdata", ms_o_mem_wdata, 32'h1234_5678);
        ms_i_mem_ack = 1'b1;
        tick();
        ms_i_mem_ack = 1'b0;
        chk("st_req_done", 32'(ms_o_mem_req), 0);
        tick();

        // Misaligned LOAD 0x102: no request, immediate error
        expect_res(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, OP_LOAD, 6'h00, 1'b0);
        drive(OP_LOAD, 6'h00, 32'h0000_0102, 32'h0, 5'd4, 1'b0);
        tick();
        ms_i_ce = 1'b0;
        chk("mis_req", 32'(ms_o_mem_req), 0);
        chk("mis_stall", 32'(ms_o_stall), 0);
        tick();

        // LOAD with no ack: abort after TIMEOUT WAIT edges
        expect_res(32'h0, 5'd6, 1'b0, 1'b1, 1'b1, OP_LOAD, 6'h00, 1'b0);
        drive(OP_LOAD, 6'h00, 32'h0000_0300, 32'h0, 5'd6, 1'b0);
        tick();
        ms_i_ce = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_req_wait", 32'(ms_o_mem_req), 1);
            chk("to_addr", ms_o_mem_addr, 32'h300);
            tick();
        end
        chk("to_req_drop", 32'(ms_o_mem_req), 0);
        chk("to_stall_drop", 32'(ms_o_stall), 0);
        tick();

        // Reset mid-WAIT, then a late ack that must be ignored
        drive(OP_LOAD, 6'h00, 32'h0000_0400, 32'h0, 5'd8, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        chk("rst_wait_req", 32'(ms_o_mem_req), 1);
        tick();
        ms_rst = 1'b1;
        tick();
        ms_rst = 1'b0;
        chk_all_zero("midrst");
        ms_i_mem_ack = 1'b1; ms_i_mem_rdata = 32'hAAAA_5555;
        tick(); tick();
        ms_i_mem_ack = 1'b0;
        chk_all_zero("lateack");
        tick(); tick();

        chk("pending_results", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory-access stage placed directly downstream of the execute stage. It consumes the registered ALU result, opcode, funct, zero flag and valid strobe, and performs word loads and stores over a request/acknowledge data-memory port. It stalls upstream while a transfer is outstanding, flags misaligned or timed-out accesses, and presents a registered result to the write-back stage.

## Interface
- DWIDTH, 32, data and address width
- RWIDTH, 5, register-index width
- TIMEOUT, 255, max cycles in WAIT before abort (≥1)

- ms_clk  in  1  clock, rising edge
- ms_rst  in  1  reset; one clock, reset is synchronous and active-high
- ms_i_ce  in  1  input valid (from execute es_o_ce)
- ms_i_opcode  in  `OPCODE_WIDTH  opcode
- ms_i_funct  in  `FUNCT_WIDTH  funct, passed through
- ms_i_alu_value  in  DWIDTH  ALU result / effective address
- ms_i_zero  in  1  zero flag, passed through
- ms_i_store_data  in  DWIDTH  rt value for STORE
- ms_i_rd  in  RWIDTH  destination register index
- ms_o_stall  out  1  upstream must hold inputs
- ms_o_mem_req  out  1  memory request
- ms_o_mem_we  out  1  1 = write
- ms_o_mem_addr  out  DWIDTH  word-aligned address
- ms_o_mem_wdata  out  DWIDTH  write data
- ms_i_mem_ack  in  1  memory completes request this cycle
- ms_i_mem_rdata  in  DWIDTH  read data, valid with ack
- ms_o_ce  out  1  result valid, one-cycle pulse per instruction
- ms_o_wb_data  out  DWIDTH  load data or ALU result
- ms_o_rd  out  RWIDTH  destination index
- ms_o_regwrite  out  1  write-back enable
- ms_o_opcode / ms_o_funct / ms_o_zero  out  as inputs  registered pass-through
- ms_o_err  out  1  misaligned or timed-out access

## Operation
- FSM states: IDLE, WAIT.
- IDLE, ms_i_ce=0: ms_o_ce←0, ms_o_wb_data←0, ms_o_regwrite←0, ms_o_err←0. Opcode/funct/rd hold.
- IDLE, ms_i_ce=1, opcode not LOAD/STORE: ms_o_wb_data←alu_value, regwrite←1, ce←1, err←0, pass-through fields registered.
- IDLE, ms_i_ce=1, LOAD/STORE, alu_value[1:0]≠0: no request; ce←1, err←1, regwrite←0, wb_data←0.
- IDLE, ms_i_ce=1, LOAD/STORE, aligned: latch addr, wdata (STORE only, else 0), we, rd, opcode, funct, zero; mem_req←1; counter←0; ce←0; →WAIT.
- WAIT, ack=1: mem_req←0, ce←1, err←0; LOAD: wb_data←mem_rdata, regwrite←1; STORE: wb_data←addr, regwrite←0; →IDLE.
- WAIT, ack=0, counter=TIMEOUT−1: mem_req←0, ce←1, err←1, regwrite←0, wb_data←0; →IDLE. Otherwise counter+1.
- ms_o_stall = (state==WAIT), combinational from state register; inputs ignored while high.
- mem_addr/mem_wdata/mem_we stable for the whole time mem_req=1.
- ms_i_mem_ack in IDLE ignored.

## Timing
- Reset (ms_rst=1 at edge): state IDLE, counter 0; all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, ce, wb_data, rd, regwrite, opcode, funct, zero, err); stall 0.
- Reset mid-WAIT aborts transfer: mem_req low after that edge, no ms_o_ce pulse; an ack arriving after reset is ignored.
- Non-memory op: 1-cycle latency (input edge N, ms_o_ce high after N).
- Memory op: accepted at edge N, mem_req high from N; ack sampled at edge N+k (k≥1) → result at N+k; minimum latency 2 edges from input to ce at N+1 when ack in first WAIT cycle.
- Timeout: ce/err after exactly TIMEOUT edges in WAIT without ack.
- Stall deasserts at the same edge the result is registered; next instruction may be accepted that following cycle (back-to-back memory ops: one IDLE cycle between requests).

## Structure
- `OPCODE_WIDTH, `FUNCT_WIDTH, `LOAD, `STORE already in header.vh; add state encodings MS_IDLE/MS_WAIT there.
- No sub-module required; request FSM and timeout counter stay in one module. Instantiated between execute and write-back in the top level.

## Test plan
- R-type ADD, alu_value=0x0000_0007, rd=3, ce=1 → next cycle ce=1, wb_data=7, rd=3, regwrite=1, err=0, stall=0.
- LOAD addr 0x100, ack after 3 WAIT cycles with rdata=0xDEAD_BEEF → stall high 3 cycles, req/addr=0x100/we=0 stable, then ce=1, wb_data=0xDEADBEEF, regwrite=1.
- STORE addr 0x204, store_data=0x1234_5678, ack on first WAIT cycle → mem_we=1, wdata=0x12345678, ce=1, regwrite=0.
- LOAD addr 0x102 → no mem_req, next cycle ce=1, err=1, regwrite=0.
- LOAD with TIMEOUT=4, ack never → req drops after 4 WAIT cycles, ce=1, err=1, wb_data=0.
- ms_rst=1 during WAIT, then late ack → all outputs 0, no ce pulse, state IDLE.
